avalon_slave_ram: RTL and testbench

- Avalon-MM slave (responder) word-addressed RAM; the target end of the RISC-V core's Avalon master data/instruction port.
- Accepts single-beat reads and writes, inserts a configurable number of waitrequest cycles per command, and returns read data over a fixed-latency pipelined readdatavalid path.
- Used as the bench/system memory behind the master.

---
 rtl/avalon_pkg.sv | 13 +
 rtl/avalon_ram_array.sv | 29 ++
 rtl/avalon_slave_ram.sv | 113 +++++++++++
 tb/tb_avalon_slave_ram.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared Avalon-MM constants and helpers for the slave RAM and its word array.
package avalon_pkg;

    localparam int AV_DATA_W           = 32;
    localparam int AV_BE_W             = 4;
    localparam int AV_MAX_READ_LATENCY = 8;

    // Width of a counter that must reach wait_cycles; never narrower than one bit.
    function automatic int wcnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/avalon_ram_array.sv
// Byte-enabled word array: synchronous write, combinational read, no reset.
module avalon_ram_array
    import avalon_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [AV_DATA_W-1:0]  wdata,
    input  logic [AV_BE_W-1:0]    be,
    output logic [AV_DATA_W-1:0]  rdata
);

    logic [AV_DATA_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < AV_BE_W; i++) begin
                if (be[i]) begin
                    mem[address][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[address];

endmodule

// File: rtl/avalon_slave_ram.sv
// Avalon-MM slave RAM: fixed waitrequest stall per command and a pipelined
// fixed-latency readdatavalid return path.
module avalon_slave_ram
    import avalon_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int WAIT_CYCLES  = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [AV_DATA_W-1:0]  writedata,
    input  logic [AV_BE_W-1:0]    byteenable,
    output logic                  waitrequest,
    output logic [AV_DATA_W-1:0]  readdata,
    output logic                  readdatavalid
);

    localparam int                WCNT_W   = wcnt_width(WAIT_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_CYCLES);

    if (READ_LATENCY < 1 || READ_LATENCY > AV_MAX_READ_LATENCY) begin : g_bad_latency
        $error("avalon_slave_ram: READ_LATENCY out of range 1..8");
    end

    logic                 command;
    logic                 accept;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [WCNT_W-1:0]    wcnt_reg;
    logic [WCNT_W-1:0]    wcnt_next;
    logic [AV_DATA_W-1:0] ram_rdata;

    assign command     = read | write;
    assign waitrequest = command && (wcnt_reg != WCNT_MAX);
    assign accept      = command && !waitrequest;
    assign wr_accept   = accept && write;
    // A simultaneous write takes priority and swallows the read.
    assign rd_accept   = accept && read && !write;

    // Counter clears on accept and also when the master drops the command early.
    always_comb begin
        wcnt_next = '0;
        if (command && !accept) begin
            wcnt_next = wcnt_reg + WCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_reg <= '0;
        end else begin
            wcnt_reg <= wcnt_next;
        end
    end

    avalon_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (wr_accept),
        .address (address),
        .wdata   (writedata),
        .be      (byteenable),
        .rdata   (ram_rdata)
    );

    logic                 valid_pipe     [READ_LATENCY];
    logic [AV_DATA_W-1:0] data_pipe      [READ_LATENCY];
    logic                 stage_valid_in [READ_LATENCY];
    logic [AV_DATA_W-1:0] stage_data_in  [READ_LATENCY];

    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_valid_in[gi] = rd_accept;
            assign stage_data_in[gi]  = ram_rdata;
        end else begin : g_body
            assign stage_valid_in[gi] = valid_pipe[gi-1];
            assign stage_data_in[gi]  = data_pipe[gi-1];
        end

        if (gi == READ_LATENCY - 1) begin : g_out
            // Output stage only loads on a valid beat so readdata holds between reads.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_pipe[gi] <= 1'b0;
                    data_pipe[gi]  <= '0;
                end else begin
                    valid_pipe[gi] <= stage_valid_in[gi];
                    if (stage_valid_in[gi]) begin
                        data_pipe[gi] <= stage_data_in[gi];
                    end
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_pipe[gi] <= 1'b0;
                end else begin
                    valid_pipe[gi] <= stage_valid_in[gi];
                end
                data_pipe[gi] <= stage_data_in[gi];
            end
        end
    end

    assign readdata      = data_pipe[READ_LATENCY-1];
    assign readdatavalid = valid_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_slave_ram.sv
// Directed bench: instance A (WAIT_CYCLES=1, READ_LATENCY=2), instance B (0, 3).
module tb_avalon_slave_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [9:0]  a_address;
    logic        a_read, a_write;
    logic [31:0] a_writedata;
    logic [3:0]  a_byteenable;
    logic        a_waitrequest;
    logic [31:0] a_readdata;
    logic        a_readdatavalid;

    logic [9:0]  b_address;
    logic        b_read, b_write;
    logic [31:0] b_writedata;
    logic [3:0]  b_byteenable;
    logic        b_waitrequest;
    logic [31:0] b_readdata;
    logic        b_readdatavalid;

    avalon_slave_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .READ_LATENCY(2)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (a_address),
        .read          (a_read),
        .write         (a_write),
        .writedata     (a_writedata),
        .byteenable    (a_byteenable),
        .waitrequest   (a_waitrequest),
        .readdata      (a_readdata),
        .readdatavalid (a_readdatavalid)
    );

    avalon_slave_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .READ_LATENCY(3)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (b_address),
        .read          (b_read),
        .write         (b_write),
        .writedata     (b_writedata),
        .byteenable    (b_byteenable),
        .waitrequest   (b_waitrequest),
        .readdata      (b_readdata),
        .readdatavalid (b_readdatavalid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One command on A: expect exactly one waitrequest cycle, then latency-2 return if a read.
    task automatic bus_a(input logic rd, input logic wr, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic exp_rdv, input logic [31:0] exp_data, input string tag);
        int waits;
        int lat;
        int pulses;
        logic [31:0] got;
        @(posedge clk); #1;
        a_read = rd; a_write = wr; a_address = addr; a_writedata = wd; a_byteenable = be;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!a_waitrequest) break;
            waits++;
            if (waits > 20) break;
            @(posedge clk); #1;
        end
        check({tag, " waits"}, 32'(waits), 32'd1);
        @(posedge clk); #1;
        a_read = 1'b0; a_write = 1'b0;
        lat = 0; pulses = 0; got = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (a_readdatavalid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    got = a_readdata;
                end
            end
        end
        check({tag, " latency"}, 32'(lat), exp_rdv ? 32'd2 : 32'd0);
        check({tag, " pulses"}, 32'(pulses), exp_rdv ? 32'd1 : 32'd0);
        if (exp_rdv) begin
            check({tag, " data"}, got, exp_data);
            check({tag, " hold"}, a_readdata, exp_data);
        end
        $display("txn A %s rd=%0b wr=%0b addr=0x%03h wd=0x%08h be=%04b waits=%0d lat=%0d data=0x%08h",
                 tag, rd, wr, addr, wd, be, waits, lat, got);
    endtask

    // B scoreboard: expected read data and the cycle it is due in.
    logic [31:0] exp_q[$];
    int          due_q[$];
    int          cyc_b = 0;

    task automatic b_check_cycle(input string tag);
        if (due_q.size() > 0 && due_q[0] == cyc_b) begin
            check({tag, " rdv"}, 32'(b_readdatavalid), 32'd1);
            check({tag, " data"}, b_readdata, exp_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            check({tag, " rdv"}, 32'(b_readdatavalid), 32'd0);
        end
    endtask

    // One cycle on B; with no wait states every command is accepted in its own cycle.
    task automatic b_step(input logic rd, input logic wr, input logic [9:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] exp_data, input string tag);
        @(posedge clk); #1;
        b_read = rd; b_write = wr; b_address = addr; b_writedata = wd; b_byteenable = be;
        cyc_b++;
        if (rd && !wr) begin
            exp_q.push_back(exp_data);
            due_q.push_back(cyc_b + 3);
        end
        @(negedge clk);
        check({tag, " wait"}, 32'(b_waitrequest), 32'd0);
        b_check_cycle(tag);
        if (rd || wr)
            $display("txn B %s rd=%0b wr=%0b addr=0x%03h wd=0x%08h be=%04b cyc=%0d",
                     tag, rd, wr, addr, wd, be, cyc_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_address = '0; a_read = 1'b0; a_write = 1'b0; a_writedata = '0; a_byteenable = '0;
        b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0; b_byteenable = '0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst a_wait", 32'(a_waitrequest), 32'd0);
            check("rst a_rdv", 32'(a_readdatavalid), 32'd0);
            check("rst a_rdata", a_readdata, 32'd0);
            check("rst b_rdv", 32'(b_readdatavalid), 32'd0);
            check("rst b_rdata", b_readdata, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle a_rdv", 32'(a_readdatavalid), 32'd0);
            check("idle b_rdv", 32'(b_readdatavalid), 32'd0);
        end

        bus_a(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "wr5");
        bus_a(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, "rd5");
        bus_a(1'b0, 1'b1, 10'h005, 32'h11223344, 4'b0101, 1'b0, 32'h0, "wr5_part");
        bus_a(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b1, 32'hDE22BE44, "rd5_part");
        bus_a(1'b0, 1'b1, 10'h005, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, "wr5_nobe");
        bus_a(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b1, 32'hDE22BE44, "rd5_nobe");
        bus_a(1'b1, 1'b1, 10'h010, 32'h0000CAFE, 4'hF, 1'b0, 32'h0, "rdwr10");
        bus_a(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b1, 32'h0000CAFE, "rd10");

        cyc_b = 0;
        b_step(1'b0, 1'b1, 10'h001, 32'h000000A1, 4'hF, 32'h0, "pre1");
        b_step(1'b0, 1'b1, 10'h002, 32'h000000A2, 4'hF, 32'h0, "pre2");
        b_step(1'b0, 1'b1, 10'h003, 32'h000000A3, 4'hF, 32'h0, "pre3");
        b_step(1'b0, 1'b1, 10'h004, 32'h000000A4, 4'hF, 32'h0, "pre4");
        b_step(1'b0, 1'b1, 10'h007, 32'hFFFFFFFF, 4'hF, 32'h0, "raw_w1");
        b_step(1'b0, 1'b1, 10'h007, 32'h000000AB, 4'b0001, 32'h0, "raw_w2");
        b_step(1'b1, 1'b0, 10'h007, 32'h0, 4'h0, 32'hFFFFFFAB, "raw_rd");
        b_step(1'b1, 1'b0, 10'h001, 32'h0, 4'h0, 32'h000000A1, "b2b_rd1");
        b_step(1'b1, 1'b0, 10'h002, 32'h0, 4'h0, 32'h000000A2, "b2b_rd2");
        b_step(1'b1, 1'b0, 10'h003, 32'h0, 4'h0, 32'h000000A3, "b2b_rd3");
        b_step(1'b1, 1'b0, 10'h004, 32'h0, 4'h0, 32'h000000A4, "b2b_rd4");
        for (int i = 0; i < 6; i++)
            b_step(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 32'h0, "b2b_drain");
        check("b2b all returned", 32'(due_q.size()), 32'd0);

        b_step(1'b1, 1'b0, 10'h001, 32'h0, 4'h0, 32'h000000A1, "fly_rd1");
        b_step(1'b1, 1'b0, 10'h002, 32'h0, 4'h0, 32'h000000A2, "fly_rd2");
        @(posedge clk); #1;
        b_read = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        cyc_b++;
        @(negedge clk);
        check("fly rst rdv", 32'(b_readdatavalid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc_b++;
        @(negedge clk);
        check("fly post rdv", 32'(b_readdatavalid), 32'd0);
        check("fly post rdata", b_readdata, 32'd0);
        $display("txn B reset with two reads in flight cyc=%0d", cyc_b);
        for (int i = 0; i < 5; i++)
            b_step(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 32'h0, "fly_quiet");
        b_step(1'b1, 1'b0, 10'h002, 32'h0, 4'h0, 32'h000000A2, "post_rd2");
        for (int i = 0; i < 4; i++)
            b_step(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 32'h0, "post_drain");
        check("post all returned", 32'(due_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
